// File: rtl/io_sequence_monitor_pkg.sv
// Shared state encoding and width helpers for the IO sequence monitor.
package io_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_e;

    // Table index width; a one-entry table still gets a one-bit index.
    function automatic int unsigned idx_width(input int unsigned depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

    function automatic int unsigned count_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned IDX_W_DEFAULT = idx_width(DEPTH_DEFAULT);
    localparam int unsigned NUM_W_DEFAULT = IDX_W_DEFAULT + 1;

endpackage

// File: rtl/io_sequence_monitor_if.sv
// Pattern-table, control and status bundle of the IO sequence monitor.
interface io_sequence_monitor_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TMO_W = 20
);
    import io_mon_pkg::*;

    localparam int unsigned IDX_W = idx_width(DEPTH);

    logic [WIDTH-1:0] io_in;
    logic             pat_we;
    logic [IDX_W-1:0] pat_addr;
    logic [WIDTH-1:0] pat_data;
    logic [WIDTH-1:0] pat_mask;
    logic [IDX_W:0]   num_pat;
    logic [TMO_W-1:0] tmo_limit;
    logic             start;
    logic             abort;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [IDX_W-1:0] idx;

    modport master (
        output io_in, pat_we, pat_addr, pat_data, pat_mask, num_pat, tmo_limit, start, abort,
        input  busy, pass, fail, idx
    );

    modport slave (
        input  io_in, pat_we, pat_addr, pat_data, pat_mask, num_pat, tmo_limit, start, abort,
        output busy, pass, fail, idx
    );

endinterface

// File: rtl/io_sync2.sv
// Two-flop synchronizer bringing the asynchronous IO bus into the wb_clk_i domain.
module io_sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/io_sequence_monitor.sv
// Watches a synchronised IO bus for a programmed sequence of masked patterns,
// each held STABLE cycles, with an optional per-pattern timeout.
module io_sequence_monitor
    import io_mon_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STABLE = 2,
    parameter int unsigned TMO_W  = 20
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    io_sequence_monitor_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned NUM_W = IDX_W + 1;
    localparam int unsigned STB_W = count_width(STABLE);

    logic [WIDTH-1:0] io_sync_s;
    logic [WIDTH-1:0] pat_data_r [DEPTH];
    logic [WIDTH-1:0] pat_mask_r [DEPTH];
    mon_state_e       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [NUM_W-1:0] num_pat_r;
    logic [TMO_W-1:0] tmo_limit_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [STB_W-1:0] stable_r;
    logic             busy_r;
    logic             pass_r;
    logic             fail_r;

    logic             match_s;
    logic             accept_s;
    logic             timeout_s;
    logic             last_s;
    logic             start_ok_s;
    logic             wr_ok_s;
    logic [STB_W-1:0] stable_nxt_s;
    logic [TMO_W-1:0] tmo_nxt_s;

    io_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (bus.io_in),
        .q   (io_sync_s)
    );

    // Match, saturating counter increments and transition qualifiers.
    always_comb begin
        match_s = (((io_sync_s ^ pat_data_r[idx_r]) & pat_mask_r[idx_r]) == {WIDTH{1'b0}});
        if (stable_r == {STB_W{1'b1}}) begin
            stable_nxt_s = stable_r;
        end else begin
            stable_nxt_s = stable_r + 1'b1;
        end
        if (tmo_cnt_r == {TMO_W{1'b1}}) begin
            tmo_nxt_s = tmo_cnt_r;
        end else begin
            tmo_nxt_s = tmo_cnt_r + 1'b1;
        end
        accept_s   = match_s && (stable_nxt_s == STB_W'(STABLE));
        timeout_s  = (tmo_limit_r != {TMO_W{1'b0}}) && (tmo_nxt_s >= tmo_limit_r);
        last_s     = ((NUM_W'(idx_r) + 1'b1) == num_pat_r);
        start_ok_s = bus.start && (bus.num_pat != {NUM_W{1'b0}}) && (bus.num_pat <= NUM_W'(DEPTH));
        wr_ok_s    = bus.pat_we && (state_r != ST_WAIT) && (NUM_W'(bus.pat_addr) < NUM_W'(DEPTH));
    end

    // Pattern table: frozen while a sequence is being watched.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pat_data_r[i] <= {WIDTH{1'b0}};
                pat_mask_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            pat_data_r[bus.pat_addr] <= bus.pat_data;
            pat_mask_r[bus.pat_addr] <= bus.pat_mask;
        end
    end

    // Sequence FSM with registered status; abort overrides everything but reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            num_pat_r   <= {NUM_W{1'b0}};
            tmo_limit_r <= {TMO_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            stable_r    <= {STB_W{1'b0}};
            busy_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else if (bus.abort) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IDX_W{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
            stable_r  <= {STB_W{1'b0}};
            busy_r    <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start_ok_s) begin
                        state_r     <= ST_WAIT;
                        idx_r       <= {IDX_W{1'b0}};
                        num_pat_r   <= bus.num_pat;
                        tmo_limit_r <= bus.tmo_limit;
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                        stable_r    <= {STB_W{1'b0}};
                        busy_r      <= 1'b1;
                        pass_r      <= 1'b0;
                        fail_r      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (accept_s) begin
                        stable_r  <= {STB_W{1'b0}};
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        if (last_s) begin
                            state_r <= ST_PASS;
                            busy_r  <= 1'b0;
                            pass_r  <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 1'b1;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_FAIL;
                        busy_r  <= 1'b0;
                        fail_r  <= 1'b1;
                    end else begin
                        stable_r  <= match_s ? stable_nxt_s : {STB_W{1'b0}};
                        tmo_cnt_r <= tmo_nxt_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.pass = pass_r;
    assign bus.fail = fail_r;
    assign bus.idx  = idx_r;

endmodule
